// File: rtl/ysyx22041405_ifu_if.sv
// Fetch-unit bus: instruction-memory request/response, execute redirect and IF/ID handshake.
interface ysyx22041405_ifu_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned IF_ID_WIDTH = 2 * WIDTH;

    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [WIDTH-1:0]       imem_addr;
    logic                   imem_rsp_valid;
    logic [WIDTH-1:0]       imem_rsp_data;
    logic                   redirect_valid;
    logic [WIDTH-1:0]       redirect_pc;
    logic                   IF_ID_valid;
    logic                   IF_ID_ready;
    logic [IF_ID_WIDTH-1:0] IF_ID_message;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_addr, IF_ID_valid, IF_ID_message,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, IF_ID_ready
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req_valid, imem_addr, IF_ID_valid, IF_ID_message,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, IF_ID_ready
    );
endinterface

// File: rtl/ysyx22041405_ifu.sv
// Instruction fetch unit: one outstanding imem request, IF/ID output register with
// a one-entry skid buffer, and redirect-driven flush of in-flight work.
module ysyx22041405_ifu #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
    input logic                clk,
    input logic                rst,
    ysyx22041405_ifu_if.master bus
);
    localparam int unsigned IF_ID_WIDTH = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        STALL = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       pc_q, pc_d;
    logic [WIDTH-1:0]       fetch_pc_q, fetch_pc_d;
    logic                   out_valid_q, out_valid_d;
    logic [IF_ID_WIDTH-1:0] out_msg_q, out_msg_d;
    logic                   buf_valid_q, buf_valid_d;
    logic [IF_ID_WIDTH-1:0] buf_msg_q, buf_msg_d;
    logic                   drop_q, drop_d;

    logic [WIDTH-1:0]       redirect_target;
    logic                   unused_redirect_lsb;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign redirect_target     = {bus.redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    // Outputs are pure decodes of state flops.
    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_addr      = pc_q;
    assign bus.IF_ID_valid    = out_valid_q;
    assign bus.IF_ID_message  = out_msg_q;

    // Next-state, datapath and flush logic; redirect is applied last so it overrides.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        out_valid_d = out_valid_q;
        out_msg_d   = out_msg_q;
        buf_valid_d = buf_valid_q;
        buf_msg_d   = buf_msg_q;
        drop_d      = drop_q;

        if (out_valid_q && bus.IF_ID_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.imem_req_ready) begin
                    fetch_pc_d = pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else if (!out_valid_q || bus.IF_ID_ready) begin
                        out_msg_d   = {fetch_pc_q, bus.imem_rsp_data};
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + WIDTH'(4);
                        state_d     = REQ;
                    end else begin
                        buf_msg_d   = {fetch_pc_q, bus.imem_rsp_data};
                        buf_valid_d = 1'b1;
                        pc_d        = pc_q + WIDTH'(4);
                        state_d     = STALL;
                    end
                end
            end
            STALL: begin
                if (bus.IF_ID_ready) begin
                    out_msg_d   = buf_msg_q;
                    out_valid_d = 1'b1;
                    buf_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect_valid) begin
            pc_d        = redirect_target;
            out_valid_d = 1'b0;
            buf_valid_d = 1'b0;
            case (state_q)
                REQ: begin
                    state_d = bus.imem_req_ready ? WAIT : REQ;
                    drop_d  = bus.imem_req_ready;
                end
                WAIT: begin
                    state_d = bus.imem_rsp_valid ? REQ : WAIT;
                    drop_d  = !bus.imem_rsp_valid;
                end
                default: begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= '0;
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_msg_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
            buf_valid_q <= buf_valid_d;
            buf_msg_q   <= buf_msg_d;
            drop_q      <= drop_d;
        end
    end
endmodule

// File: tb/tb_ysyx22041405_ifu.sv
// Bench for ysyx22041405_ifu: memory model with configurable latency, scoreboards of
// expected fetch addresses and IF/ID messages, plus a redirect vector table.
module tb_ysyx22041405_ifu;
    localparam int unsigned WIDTH  = 32;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } redir_vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx22041405_ifu_if #(.WIDTH(WIDTH)) bus ();
    ysyx22041405_ifu #(.WIDTH(WIDTH), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc, t_req, t_val, t_last, acc_cnt, lat, mem_cnt;
    bit          mem_busy;
    logic [31:0] mem_addr;
    logic [31:0] addr_q[$];
    logic [63:0] msg_q[$];
    redir_vec_t  tbl[4];

    // Instruction memory contents: 0x8000_0000 holds 0x0000_0013.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h8000_0013;
    endfunction

    function automatic logic [63:0] msg_of(input logic [31:0] a);
        return {a, mem_word(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock: drive memory response, score handshakes, advance the edge.
    task automatic cycle();
        logic        acc;
        logic        rsp_now;
        logic [31:0] acc_addr;
        logic [63:0] exp;
        cyc++;
        bus.imem_rsp_valid = mem_busy && (mem_cnt == 0);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        if (bus.imem_req_valid && t_req < 0) t_req = cyc;
        if (bus.IF_ID_valid && bus.IF_ID_ready) begin
            if (t_val < 0) t_val = cyc;
            t_last = cyc;
            if (msg_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_msg: got %h, want none", bus.IF_ID_message);
            end else begin
                exp = msg_q.pop_front();
                chk("if_id_msg", bus.IF_ID_message, exp);
            end
        end
        acc      = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_addr;
        if (acc) begin
            acc_cnt++;
            if (addr_q.size() != 0) chk("imem_addr", 64'(acc_addr), 64'(addr_q.pop_front()));
        end
        rsp_now = bus.imem_rsp_valid;
        @(posedge clk);
        #1;
        if (rsp_now) mem_busy = 1'b0;
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = acc_addr;
            mem_cnt  = lat - 1;
        end else if (mem_busy && mem_cnt > 0) begin
            mem_cnt--;
        end
    endtask

    // One reset edge; leaves the DUT in IDLE with rst released.
    task automatic do_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.IF_ID_ready    = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        @(posedge clk);
        #1;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        cyc      = 0;
        t_req    = -1;
        t_val    = -1;
        t_last   = -1;
        acc_cnt  = 0;
        addr_q.delete();
        msg_q.delete();
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_if_id_valid", 64'(bus.IF_ID_valid), 64'd0);
        chk("rst_if_id_msg", bus.IF_ID_message, 64'd0);
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((msg_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (msg_q.size() != 0 || addr_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d msgs %0d addrs left, want 0",
                     msg_q.size(), addr_q.size());
            msg_q.delete();
            addr_q.delete();
        end
        bus.IF_ID_ready    = 1'b0;
        bus.imem_req_ready = 1'b0;
    endtask

    // Reset, then stall decode until the second instruction sits in the skid buffer.
    task automatic fill_stall();
        do_reset();
        lat                = 1;
        bus.IF_ID_ready    = 1'b0;
        bus.imem_req_ready = 1'b1;
        addr_q.push_back(32'h8000_0000);
        addr_q.push_back(32'h8000_0004);
        repeat (7) cycle();
    endtask

    initial begin
        logic [63:0] first_msg;
        bit          have_first;
        bit          stable;

        tbl[0] = '{rpc: 32'h8000_0100, pc0: 32'h8000_0100, pc1: 32'h8000_0104};
        tbl[1] = '{rpc: 32'h8000_0203, pc0: 32'h8000_0200, pc1: 32'h8000_0204};
        tbl[2] = '{rpc: 32'hFFFF_FFFF, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000};
        tbl[3] = '{rpc: 32'h0000_0006, pc0: 32'h0000_0004, pc1: 32'h0000_0008};

        // Zero-wait memory: first address, latency and throughput.
        do_reset();
        lat                = 1;
        bus.IF_ID_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr_q.push_back(RST_PC + 32'(4 * k));
            msg_q.push_back(msg_of(RST_PC + 32'(4 * k)));
        end
        drain(20);
        chk("first_req_cycle", 64'(t_req), 64'd2);
        chk("req_to_valid", 64'(t_val - t_req), 64'd2);
        chk("three_insts_span", 64'(t_last - t_val), 64'd4);

        // Backpressure: skid buffer fills, no third request, output stable.
        do_reset();
        lat                = 1;
        bus.IF_ID_ready    = 1'b0;
        bus.imem_req_ready = 1'b1;
        addr_q.push_back(32'h8000_0000);
        addr_q.push_back(32'h8000_0004);
        have_first = 1'b0;
        stable     = 1'b1;
        repeat (12) begin
            cycle();
            if (bus.IF_ID_valid) begin
                if (!have_first) begin
                    have_first = 1'b1;
                    first_msg  = bus.IF_ID_message;
                end else if (bus.IF_ID_message !== first_msg) begin
                    stable = 1'b0;
                end
            end
        end
        chk("stall_req_count", 64'(acc_cnt), 64'd2);
        chk("stall_msg_stable", 64'(stable), 64'd1);
        chk("stall_if_id_valid", 64'(bus.IF_ID_valid), 64'd1);
        chk("stall_if_id_msg", bus.IF_ID_message, {32'h8000_0000, 32'h0000_0013});
        chk("stall_no_req", 64'(bus.imem_req_valid), 64'd0);
        msg_q.push_back(msg_of(32'h8000_0000));
        msg_q.push_back(msg_of(32'h8000_0004));
        addr_q.push_back(32'h8000_0008);
        bus.IF_ID_ready = 1'b1;
        drain(20);

        // Redirect while waiting on a slow response: that response is dropped.
        do_reset();
        lat                = 3;
        bus.IF_ID_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        addr_q.push_back(32'h8000_0000);
        addr_q.push_back(32'h8000_0100);
        msg_q.push_back(msg_of(32'h8000_0100));
        repeat (2) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        cycle();
        bus.redirect_valid = 1'b0;
        drain(30);

        // Redirect in the handshake cycle with an unaligned target.
        do_reset();
        lat                = 1;
        bus.IF_ID_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        addr_q.push_back(32'h8000_0000);
        addr_q.push_back(32'h8000_0200);
        addr_q.push_back(32'h8000_0204);
        msg_q.push_back(msg_of(32'h8000_0200));
        msg_q.push_back(msg_of(32'h8000_0204));
        cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0203;
        cycle();
        bus.redirect_valid = 1'b0;
        drain(20);

        // Redirect in STALL flushes both entries; target wraps past 2^32.
        fill_stall();
        chk("pre_flush_valid", 64'(bus.IF_ID_valid), 64'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("flush_if_id_valid", 64'(bus.IF_ID_valid), 64'd0);
        chk("flush_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("flush_addr", 64'(bus.imem_addr), 64'hFFFF_FFFC);
        addr_q.push_back(32'hFFFF_FFFC);
        addr_q.push_back(32'h0000_0000);
        msg_q.push_back(msg_of(32'hFFFF_FFFC));
        msg_q.push_back(msg_of(32'h0000_0000));
        bus.IF_ID_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        drain(20);

        // Table: redirect in REQ with no handshake switches the address next cycle.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            lat                = 1;
            bus.IF_ID_ready    = 1'b1;
            bus.imem_req_ready = 1'b0;
            cycle();
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = tbl[i].rpc;
            cycle();
            bus.redirect_valid = 1'b0;
            chk("tbl_redirect_addr", 64'(bus.imem_addr), 64'(tbl[i].pc0));
            addr_q.push_back(tbl[i].pc0);
            addr_q.push_back(tbl[i].pc1);
            msg_q.push_back(msg_of(tbl[i].pc0));
            msg_q.push_back(msg_of(tbl[i].pc1));
            bus.imem_req_ready = 1'b1;
            drain(20);
        end

        // Reset in STALL with a full skid buffer restarts at RESET_PC.
        fill_stall();
        chk("pre_reset_valid", 64'(bus.IF_ID_valid), 64'd1);
        do_reset();
        addr_q.push_back(RST_PC);
        msg_q.push_back({32'h8000_0000, 32'h0000_0013});
        lat                = 1;
        bus.IF_ID_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
